div_iter_32_bit: RTL and testbench



---
 rtl/div_iter_32_bit_pkg.sv | 22 ++
 rtl/div_iter_32_bit_if.sv | 24 ++
 rtl/adder_cla_32_bit.sv | 38 +++
 rtl/div_iter_32_bit_step.sv | 32 +++
 rtl/div_iter_32_bit.sv | 107 ++++++++++
 tb/tb_div_iter_32_bit.sv | 173 +++++++++++++++++
 6 files changed

// File: rtl/div_iter_32_bit_pkg.sv
// Shared constants, state encodings and helpers for the iterative 32-bit divider.
package div_pkg;

  localparam int WIDTH   = 32;
  localparam int ITER    = WIDTH;
  localparam int COUNT_W = 6;

  localparam logic [WIDTH-1:0] INT_MIN = 32'h8000_0000;
  localparam logic [WIDTH-1:0] NEG_ONE = 32'hFFFF_FFFF;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  // Unsigned magnitude of a two's-complement value; INT_MIN maps to 0x80000000.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/div_iter_32_bit_if.sv
// Start/ready handshake and operand/result bus of the iterative divider.
interface div_iter_32_bit_if;
  import div_pkg::*;

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             ready;
  logic             exception;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, ready, exception
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, ready, exception
  );

endinterface

// File: rtl/adder_cla_32_bit.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups with the group carry chained.
module adder_cla_32_bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Each group resolves its internal carries from the incoming group carry.
  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int k = 0; k < 8; k++) begin
      c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
               | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+4] = g[4*k+3] | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
    end
  end

  assign sum  = p ^ c[31:0];
  assign cout = c[32];

endmodule

// File: rtl/div_iter_32_bit_step.sv
// One combinational restoring-division step. The shifted partial remainder is
// 33 bits wide; its low 32 bits go through the CLA adder as rem + ~divisor + 1,
// and the trial result is non-negative when the shifted-out bit or the adder
// carry is set, so the subtract never wraps even for a 0x80000000 divisor.
module div_step_32_bit
  import div_pkg::*;
(
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor_mag,
  output logic [WIDTH-1:0] rem_out,
  output logic             quo_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             carry;

  assign shifted = {rem_in, dividend_bit};

  adder_cla_32_bit u_sub (
    .a    (shifted[WIDTH-1:0]),
    .b    (~divisor_mag),
    .cin  (1'b1),
    .sum  (diff),
    .cout (carry)
  );

  assign quo_bit = shifted[WIDTH] | carry;
  assign rem_out = quo_bit ? diff : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_iter_32_bit.sv
// Multicycle signed 32-bit restoring divider, one quotient bit per clock.
// Optional build macro DIV_EARLY_TERM_EN: when |dividend| < |divisor| the
// result is produced one edge after start instead of after the full iteration.
module div_iter_32_bit
  import div_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  div_iter_32_bit_if.slave   bus
);

  state_t             state;
  logic [COUNT_W-1:0] count;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic [WIDTH-1:0]   divisor_mag;
  logic               quo_neg;
  logic               rem_neg;
  logic               exc_pending;

  logic [WIDTH-1:0]   dividend_mag;
  logic [WIDTH-1:0]   divisor_in_mag;
  logic [WIDTH-1:0]   rem_next;
  logic               quo_bit;

  assign dividend_mag   = magnitude(bus.dividend);
  assign divisor_in_mag = magnitude(bus.divisor);

  div_step_32_bit u_step (
    .rem_in       (rem_q),
    .dividend_bit (quo_q[WIDTH-1]),
    .divisor_mag  (divisor_mag),
    .rem_out      (rem_next),
    .quo_bit      (quo_bit)
  );

  // Control FSM, iteration datapath and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      count         <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      divisor_mag   <= '0;
      quo_neg       <= 1'b0;
      rem_neg       <= 1'b0;
      exc_pending   <= 1'b0;
      bus.quotient  <= '0;
      bus.remainder <= '0;
      bus.busy      <= 1'b0;
      bus.ready     <= 1'b0;
      bus.exception <= 1'b0;
    end else begin
      bus.ready <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            divisor_mag <= divisor_in_mag;
            quo_neg     <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            rem_neg     <= bus.dividend[WIDTH-1];
            exc_pending <= (bus.divisor == '0) ||
                           ((bus.dividend == INT_MIN) && (bus.divisor == NEG_ONE));
            count       <= '0;
            bus.busy    <= 1'b1;
            if (bus.divisor == '0) begin
              quo_q <= '0;
              rem_q <= dividend_mag;
              state <= DONE;
            end
`ifdef DIV_EARLY_TERM_EN
            else if (dividend_mag < divisor_in_mag) begin
              quo_q <= '0;
              rem_q <= dividend_mag;
              state <= DONE;
            end
`endif
            else begin
              quo_q <= dividend_mag;
              rem_q <= '0;
              state <= RUN;
            end
          end
        end
        RUN: begin
          rem_q <= rem_next;
          quo_q <= {quo_q[WIDTH-2:0], quo_bit};
          count <= count + 1'b1;
          if (count == COUNT_W'(ITER - 1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          bus.quotient  <= quo_neg ? (~quo_q + 1'b1) : quo_q;
          bus.remainder <= rem_neg ? (~rem_q + 1'b1) : rem_q;
          bus.exception <= exc_pending;
          bus.ready     <= 1'b1;
          bus.busy      <= 1'b0;
          state         <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter_32_bit.sv
// Scoreboard bench for div_iter_32_bit: directed vectors push expected results,
// a monitor pops and compares them on every ready pulse.
module tb_div_iter_32_bit;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        exc;
    int          rdy_cyc;
  } exp_t;

  logic clock;
  logic reset_n;
  int   cyc;
  int   checks;
  int   errors;
  int   issued;
  int   results;
  exp_t sb[$];

`ifdef DIV_EARLY_TERM_EN
  localparam int SHORT_LAT = 1;
`else
  localparam int SHORT_LAT = 33;
`endif

  div_iter_32_bit_if bus ();

  div_iter_32_bit dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Free-running edge counter used to measure latency.
  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
    end
  endtask

  // Drive one start pulse; optionally record the expected result.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] q, input logic [31:0] r,
                               input logic exc, input int lat, input bit push);
    exp_t e;
    @(negedge clock);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    if (push) begin
      e.q = q; e.r = r; e.exc = exc; e.rdy_cyc = cyc + 1 + lat;
      sb.push_back(e);
      issued++;
    end
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clock);
      #2;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout pending=%0d", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: every ready pulse must match the oldest expected result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (bus.ready === 1'b1) begin
        results++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_ready actual=1 required=0");
        end else begin
          e = sb.pop_front();
          checkOutput("quotient", bus.quotient, e.q);
          checkOutput("remainder", bus.remainder, e.r);
          checkOutput("exception", {31'b0, bus.exception}, {31'b0, e.exc});
          checkOutput("latency_cycle", cyc, e.rdy_cyc);
          checkOutput("busy_at_ready", {31'b0, bus.busy}, 32'd0);
        end
      end
    end
  end

  initial begin
    cyc = 0; checks = 0; errors = 0; issued = 0; results = 0;
    reset_n = 1'b0;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (3) @(negedge clock);
    checkOutput("reset_quotient", bus.quotient, 32'd0);
    checkOutput("reset_remainder", bus.remainder, 32'd0);
    checkOutput("reset_busy", {31'b0, bus.busy}, 32'd0);
    checkOutput("reset_ready", {31'b0, bus.ready}, 32'd0);
    checkOutput("reset_exception", {31'b0, bus.exception}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    applyStimulus(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 1'b1);
    checkOutput("busy_after_start", {31'b0, bus.busy}, 32'd1);
    waitDrain(60);
    applyStimulus(-32'sd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 33, 1'b1);
    waitDrain(60);
    applyStimulus(32'd100, -32'sd7, 32'hFFFF_FFF2, 32'd2, 1'b0, 33, 1'b1);
    waitDrain(60);
    applyStimulus(-32'sd7, -32'sd2, 32'd3, 32'hFFFF_FFFF, 1'b0, 33, 1'b1);
    waitDrain(60);
    applyStimulus(32'd5, 32'd0, 32'd0, 32'd5, 1'b1, 1, 1'b1);
    waitDrain(60);
    applyStimulus(32'd6, 32'd3, 32'd2, 32'd0, 1'b0, 33, 1'b1);
    waitDrain(60);
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b1, 33, 1'b1);
    waitDrain(60);
    applyStimulus(32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0, 33, 1'b1);
    waitDrain(60);
    applyStimulus(32'h8000_0000, 32'd7, 32'hEDB6_DB6E, 32'hFFFF_FFFE, 1'b0, 33, 1'b1);
    waitDrain(60);

    // A second start while busy must be ignored.
    applyStimulus(32'd1000, 32'd9, 32'd111, 32'd1, 1'b0, 33, 1'b1);
    repeat (8) @(negedge clock);
    applyStimulus(32'd50, 32'd5, 32'd0, 32'd0, 1'b0, 0, 1'b0);
    waitDrain(60);
    repeat (40) @(negedge clock);
    checkOutput("ignored_start_results", results, issued);

    // Reset mid-divide aborts with no ready.
    applyStimulus(32'd77, 32'd3, 32'd0, 32'd0, 1'b0, 0, 1'b0);
    repeat (19) @(negedge clock);
    reset_n = 1'b0;
    #1;
    checkOutput("abort_quotient", bus.quotient, 32'd0);
    checkOutput("abort_remainder", bus.remainder, 32'd0);
    checkOutput("abort_busy", {31'b0, bus.busy}, 32'd0);
    checkOutput("abort_ready", {31'b0, bus.ready}, 32'd0);
    checkOutput("abort_exception", {31'b0, bus.exception}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (40) @(negedge clock);
    checkOutput("abort_results", results, issued);

    applyStimulus(32'd3, 32'd10, 32'd0, 32'd3, 1'b0, SHORT_LAT, 1'b1);
    waitDrain(60);
    repeat (2) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
